// File: rtl/sel_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : sel_pkg                                                   |
// | Brief  : Shared select codes, arbiter state encoding and the       |
// |          one-hot grant to select-code conversion helper.           |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package sel_pkg;

  // Select codes presented to the downstream selecter stage.
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_A    = 2'b01;
  localparam logic [1:0] SEL_B    = 2'b10;
  localparam logic [1:0] SEL_C    = 2'b11;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // One-hot grant (bit0 = A, bit1 = B, bit2 = C) to 2-bit select code.
  function automatic logic [1:0] onehot_to_sel(input logic [2:0] gnt);
    logic [1:0] sel;
    sel = SEL_NONE;
    case (gnt)
      3'b001:  sel = SEL_A;
      3'b010:  sel = SEL_B;
      3'b100:  sel = SEL_C;
      default: sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage : sel_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : rr_pick                                                   |
// | Brief  : Combinational round-robin picker. Searches the request    |
// |          vector starting at the channel after i_ptr (A->B->C->A)   |
// |          and returns the first requester as a one-hot grant.       |
// | Ports  : i_req   [2:0] request per channel (bit0 A, bit1 B, bit2 C)|
// |          i_ptr   [1:0] last granted channel as a select code       |
// |          o_gnt   [2:0] one-hot grant of the chosen channel         |
// |          o_found       1 when any channel is requesting            |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module rr_pick
  import sel_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [2:0] o_gnt,
  output logic       o_found
);

  always_comb begin
    o_gnt = 3'b000;
    case (i_ptr)
      SEL_A: begin
        if      (i_req[1]) o_gnt = 3'b010;
        else if (i_req[2]) o_gnt = 3'b100;
        else if (i_req[0]) o_gnt = 3'b001;
      end
      SEL_B: begin
        if      (i_req[2]) o_gnt = 3'b100;
        else if (i_req[0]) o_gnt = 3'b001;
        else if (i_req[1]) o_gnt = 3'b010;
      end
      // SEL_C, and SEL_NONE which never occurs, give A first priority.
      default: begin
        if      (i_req[0]) o_gnt = 3'b001;
        else if (i_req[1]) o_gnt = 3'b010;
        else if (i_req[2]) o_gnt = 3'b100;
      end
    endcase
  end

  assign o_found = |o_gnt;

endmodule : rr_pick
`default_nettype wire

// File: rtl/sel_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : sel_rr_arbiter                                            |
// | Brief  : Three-channel round-robin arbiter driving the 2-bit       |
// |          channel select of the downstream selecter stage. Each     |
// |          grant lasts at most HOLD cycles; an early request drop    |
// |          releases it. All outputs are flops.                       |
// | Ports  : CLK        clock, rising edge                             |
// |          RST        asynchronous active-high reset                 |
// |          REQ  [2:0] request per channel (bit0 A, bit1 B, bit2 C)   |
// |          SW   [1:0] select code: 00 none, 01 A, 10 B, 11 C         |
// |          GNT  [2:0] one-hot grant, 000 when SW = 00                |
// |          BUSY       1 while a channel is granted                   |
// |          LAST       1 in the final cycle of a hold window          |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module sel_rr_arbiter
  import sel_pkg::*;
#(
  parameter int HOLD = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] REQ,
  output logic [1:0] SW,
  output logic [2:0] GNT,
  output logic       BUSY,
  output logic       LAST
);

  localparam logic [3:0] c_cnt_last = 4'(HOLD - 1);

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [3:0] r_cnt;
  logic [2:0] r_gnt;
  logic [1:0] r_sw;
  logic       r_busy;
  logic       r_last;

  state_t     w_nxt_state;
  logic [1:0] w_nxt_ptr;
  logic [3:0] w_nxt_cnt;
  logic [2:0] w_nxt_gnt;
  logic       w_nxt_last;

  logic       w_cur_req;
  logic       w_keep;
  logic [1:0] w_search_ptr;
  logic [2:0] w_pick_gnt;
  logic       w_found;

  // The granted channel is still requesting.
  assign w_cur_req = |(REQ & r_gnt);
  // Keep the current grant while it is requested and the window is open.
  assign w_keep    = (r_state == GRANT) && w_cur_req && (r_cnt != c_cnt_last);

  // When leaving a grant (expiry or early release) the search starts after
  // the channel just served, so the pointer used for this search is the
  // current select code rather than the stored pointer.
  assign w_search_ptr = (r_state == GRANT) ? r_sw : r_ptr;

  rr_pick u_pick (
    .i_req   (REQ),
    .i_ptr   (w_search_ptr),
    .o_gnt   (w_pick_gnt),
    .o_found (w_found)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ptr   = r_ptr;
    w_nxt_cnt   = r_cnt;
    w_nxt_gnt   = r_gnt;
    if (w_keep) begin
      w_nxt_cnt = r_cnt + 4'd1;
    end else begin
      w_nxt_ptr = w_search_ptr;
      w_nxt_cnt = 4'd0;
      if (w_found) begin
        // A re-grant of the same channel also restarts the window.
        w_nxt_state = GRANT;
        w_nxt_gnt   = w_pick_gnt;
      end else begin
        w_nxt_state = IDLE;
        w_nxt_gnt   = 3'b000;
      end
    end
    w_nxt_last = (w_nxt_state == GRANT) && (w_nxt_cnt == c_cnt_last);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_ptr   <= SEL_C;
      r_cnt   <= 4'd0;
      r_gnt   <= 3'b000;
      r_sw    <= SEL_NONE;
      r_busy  <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_ptr   <= w_nxt_ptr;
      r_cnt   <= w_nxt_cnt;
      r_gnt   <= w_nxt_gnt;
      r_sw    <= onehot_to_sel(w_nxt_gnt);
      r_busy  <= (w_nxt_state == GRANT);
      r_last  <= w_nxt_last;
    end
  end

  assign SW   = r_sw;
  assign GNT  = r_gnt;
  assign BUSY = r_busy;
  assign LAST = r_last;

endmodule : sel_rr_arbiter
`default_nettype wire

// File: tb/tb_sel_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_sel_rr_arbiter                                         |
// | Brief  : Self-checking bench for sel_rr_arbiter. Three instances   |
// |          (HOLD = 4, 1, 3) share one request vector and are         |
// |          compared every cycle against a channel-index reference    |
// |          model, plus directed scenarios with literal expectations. |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tb_sel_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [2:0] req;

  logic [1:0] sw   [3];
  logic [2:0] gnt  [3];
  logic       busy [3];
  logic       last [3];

  int cnt_cmp;
  int cnt_bad;

  // Reference model: granted channel index (-1 none), window count,
  // last served channel index (0 A, 1 B, 2 C).
  int m_hold [3];
  int m_ch   [3];
  int m_cnt  [3];
  int m_ptr  [3];

  sel_rr_arbiter #(.HOLD(4)) u_dut0 (
    .CLK(clk), .RST(rst), .REQ(req),
    .SW(sw[0]), .GNT(gnt[0]), .BUSY(busy[0]), .LAST(last[0])
  );
  sel_rr_arbiter #(.HOLD(1)) u_dut1 (
    .CLK(clk), .RST(rst), .REQ(req),
    .SW(sw[1]), .GNT(gnt[1]), .BUSY(busy[1]), .LAST(last[1])
  );
  sel_rr_arbiter #(.HOLD(3)) u_dut2 (
    .CLK(clk), .RST(rst), .REQ(req),
    .SW(sw[2]), .GNT(gnt[2]), .BUSY(busy[2]), .LAST(last[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    cnt_cmp++;
    if (obs !== exp) begin
      cnt_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ch[k]  = -1;
      m_cnt[k] = 0;
      m_ptr[k] = 2;
    end
  endfunction

  function automatic void model_step(input logic [2:0] r);
    for (int k = 0; k < 3; k++) begin
      if (m_ch[k] >= 0 && r[m_ch[k]] && m_cnt[k] < m_hold[k] - 1) begin
        m_cnt[k]++;
      end else begin
        int nxt;
        if (m_ch[k] >= 0) m_ptr[k] = m_ch[k];
        nxt = -1;
        for (int i = 1; i <= 3; i++) begin
          int c;
          c = (m_ptr[k] + i) % 3;
          if (nxt < 0 && r[c]) nxt = c;
        end
        m_ch[k]  = nxt;
        m_cnt[k] = 0;
      end
    end
  endfunction

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      logic [1:0] e_sw;
      logic [2:0] e_gnt;
      logic       e_busy;
      logic       e_last;
      e_busy = (m_ch[k] >= 0);
      e_sw   = e_busy ? 2'(m_ch[k] + 1) : 2'b00;
      e_gnt  = e_busy ? 3'(1 << m_ch[k]) : 3'b000;
      e_last = e_busy && (m_cnt[k] == m_hold[k] - 1);
      check_val($sformatf("sw%0d", k),   8'(sw[k]),   8'(e_sw));
      check_val($sformatf("gnt%0d", k),  8'(gnt[k]),  8'(e_gnt));
      check_val($sformatf("busy%0d", k), 8'(busy[k]), 8'(e_busy));
      check_val($sformatf("last%0d", k), 8'(last[k]), 8'(e_last));
    end
  endtask

  // One clock: drive on the falling edge, step the model on the rising
  // edge, check 1 ns later.
  task automatic cycle(input logic [2:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    req = 3'b000;
    #1;
    // Asynchronous: outputs must already be cleared, no edge has passed.
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("rst_sw%0d", k),   8'(sw[k]),   8'h00);
      check_val($sformatf("rst_gnt%0d", k),  8'(gnt[k]),  8'h00);
      check_val($sformatf("rst_busy%0d", k), 8'(busy[k]), 8'h00);
      check_val($sformatf("rst_last%0d", k), 8'(last[k]), 8'h00);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] r;
    cnt_cmp   = 0;
    cnt_bad   = 0;
    m_hold[0] = 4;
    m_hold[1] = 1;
    m_hold[2] = 3;
    rst = 1'b1;
    req = 3'b000;
    model_reset();
    #12;
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) cycle(3'b000);

    // All requesting, HOLD = 4: A x4, B x4, C x4, A x4, LAST on 4th.
    for (int i = 0; i < 16; i++) begin
      cycle(3'b111);
      check_val("rr111_sw", 8'(sw[0]), 8'((i / 4) % 3 + 1));
      check_val("rr111_last", 8'(last[0]), 8'(i % 4 == 3));
    end
    // Reset mid-grant.
    do_reset();

    // Only B requesting: continuous B, LAST every 4 cycles.
    for (int i = 0; i < 12; i++) begin
      cycle(3'b010);
      check_val("b_only_sw", 8'(sw[0]), 8'h02);
      check_val("b_only_last", 8'(last[0]), 8'(i % 4 == 3));
    end

    // Early release: A granted with 101, A drops after 2 cycles -> C.
    do_reset();
    cycle(3'b101);
    cycle(3'b101);
    check_val("drop_pre_sw", 8'(sw[0]), 8'h01);
    cycle(3'b100);
    check_val("drop_sw", 8'(sw[0]), 8'h03);
    check_val("drop_ptr", 8'(u_dut0.r_ptr), 8'h01);

    // From IDLE with ptr = C, 110 grants B; later with ptr = B, 101 grants C.
    do_reset();
    cycle(3'b110);
    check_val("idle_b_sw", 8'(sw[0]), 8'h02);
    cycle(3'b000);
    cycle(3'b000);
    check_val("idle_gap_sw", 8'(sw[0]), 8'h00);
    cycle(3'b101);
    check_val("idle_c_sw", 8'(sw[0]), 8'h03);

    // HOLD = 1: 011 alternates A, B with LAST always high.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(3'b011);
      check_val("h1_sw", 8'(sw[1]), 8'((i % 2) + 1));
      check_val("h1_last", 8'(last[1]), 8'h01);
    end

    // Randomized requests with persistence so windows expire as well as drop.
    do_reset();
    r = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
      cycle(r);
      if (i == 1500) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_bad);
    $finish;
  end

endmodule : tb_sel_rr_arbiter
`default_nettype wire
